// File: rtl/mult_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: FSM states,
// Booth digit operations and the iteration count as a function of operand width.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      POS1 = 3'd1,
      POS2 = 3'd2,
      NEG1 = 3'd3,
      NEG2 = 3'd4
   } booth_op_e;

   // One radix-4 digit per two multiplier bits, plus one for the sign/zero extension.
   function automatic int booth_iters(input int width);
      return width / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: {b[2k+1], b[2k], b[2k-1]} -> digit in {-2..+2}.
module booth_r4_encoder
   import mult_pkg::*;
(
   input  logic [2:0] bits_i,
   output logic [2:0] op_o
);

   always_comb begin
      op_o = ZERO;
      case (bits_i)
         3'b001, 3'b010: op_o = POS1;
         3'b011:         op_o = POS2;
         3'b100:         op_o = NEG2;
         3'b101, 3'b110: op_o = NEG1;
         default:        op_o = ZERO;
      endcase
   end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Optional macro MULT_UNSIGNED_MODE_EN adds a signed_mode input (1 = signed, 0 = unsigned).
module booth_seq_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic               clk,
   input  logic               rst,
`ifdef MULT_UNSIGNED_MODE_EN
   input  logic               signed_mode,
`endif
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] P,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [1:0]         dbg_state_o
);

   localparam int N     = booth_iters(WIDTH);
   localparam int CNT_W = $clog2(N + 1);
   localparam int ACC_W = 2 * WIDTH + 4;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // in_ready is 1 only in IDLE, out_valid only in DONE, and both are registered.

   state_e             state_q;
   logic [ACC_W-1:0]   mcand_q;
   logic [ACC_W-1:0]   acc_q;
   logic [WIDTH+2:0]   mplr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] p_q;
   logic               in_ready_q;
   logic               out_valid_q;

   logic               sgn;
   logic [ACC_W-1:0]   a_ext;
   logic [WIDTH+1:0]   b_ext;
   logic [2:0]         op_raw;
   booth_op_e          op;
   logic [ACC_W-1:0]   pp;
   logic [ACC_W-1:0]   acc_d;

`ifdef MULT_UNSIGNED_MODE_EN
   assign sgn = signed_mode;
`else
   assign sgn = 1'b1;
`endif

   assign a_ext = {{(WIDTH + 4){sgn & A[WIDTH-1]}}, A};
   assign b_ext = {{2{sgn & B[WIDTH-1]}}, B};

   // mplr_q carries an implicit b[-1] = 0 in bit 0, so the low 3 bits are always the current digit.
   booth_r4_encoder u_enc (
      .bits_i (mplr_q[2:0]),
      .op_o   (op_raw)
   );

   assign op = booth_op_e'(op_raw);

   always_comb begin
      pp = '0;
      case (op)
         POS1:    pp = mcand_q;
         POS2:    pp = mcand_q << 1;
         NEG1:    pp = ~mcand_q + ACC_W'(1);
         NEG2:    pp = ~(mcand_q << 1) + ACC_W'(1);
         default: pp = '0;
      endcase
      acc_d = acc_q + pp;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mcand_q     <= '0;
         acc_q       <= '0;
         mplr_q      <= '0;
         cnt_q       <= '0;
         p_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  mcand_q    <= a_ext;
                  mplr_q     <= {b_ext, 1'b0};
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= CALC;
               end
            end
            CALC: begin
               // The multiplicand moves left by one digit weight as the multiplier moves right.
               acc_q   <= acc_d;
               mcand_q <= mcand_q << 2;
               mplr_q  <= mplr_q >> 2;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(N - 1)) begin
                  p_q         <= acc_d[2*WIDTH-1:0];
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  p_q         <= '0;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign P           = p_q;
   assign dbg_state_o = state_q;

endmodule
